// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: running status, per-channel filter, real-time interleave, FWFT message FIFO.
// Optional macro MIDI_DEC_REALTIME_EN: when defined, real-time bytes (except FD) are queued as len-1 messages.
module midi_msg_parser #(
  parameter int          FIFO_DEPTH       = 4,
  parameter logic [15:0] CHANNEL_MASK     = 16'hFFFF,
  parameter bit          VEL0_TO_NOTE_OFF = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_byte,
  output logic                          msg_valid,
  input  logic                          msg_ready,
  output logic [7:0]                    msg_status,
  output logic [6:0]                    msg_data1,
  output logic [6:0]                    msg_data2,
  output logic [1:0]                    msg_len,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          sync_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_D1, S_WAIT_D2, S_SYSEX} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_rs_vld, w_rs_vld_nxt;
  logic [7:0]  r_rs, w_rs_nxt;
  logic [7:0]  r_cur, w_cur_nxt;
  logic [6:0]  r_d1, w_d1_nxt;
  logic        w_push, w_push_ok, w_sync_err;
  logic [23:0] w_push_dat;
  logic [7:0]  w_d1_status, w_d2_status;

  function automatic logic is_two_byte(input logic [7:0] s);
    return (s[7:5] == 3'b110) || (s == 8'hF1) || (s == 8'hF3);
  endfunction

  // In IDLE a data byte starts a message under running status.
  assign w_d1_status = (r_state == S_IDLE) ? r_rs : r_cur;
  assign w_d2_status = (VEL0_TO_NOTE_OFF && r_cur[7:4] == 4'h9 && rx_byte[6:0] == 7'd0) ?
                       {4'h8, r_cur[3:0]} : r_cur;

  always_comb begin
    w_state_nxt  = r_state;
    w_rs_vld_nxt = r_rs_vld;
    w_rs_nxt     = r_rs;
    w_cur_nxt    = r_cur;
    w_d1_nxt     = r_d1;
    w_push       = 1'b0;
    w_push_dat   = '0;
    w_sync_err   = 1'b0;
    if (rx_valid) begin
      if (rx_byte[7:3] == 5'b11111) begin
`ifdef MIDI_DEC_REALTIME_EN
        if (rx_byte != 8'hFD) begin
          w_push     = 1'b1;
          w_push_dat = {rx_byte, 7'd0, 7'd0, 2'd1};
        end
`else
        w_push = 1'b0;
`endif
      end else if (rx_byte[7]) begin
        if (r_state == S_WAIT_D1 || r_state == S_WAIT_D2)
          w_sync_err = 1'b1;
        w_state_nxt = S_IDLE;
        w_cur_nxt   = rx_byte;
        if (rx_byte[7:4] != 4'hF) begin
          w_rs_nxt     = rx_byte;
          w_rs_vld_nxt = 1'b1;
          w_state_nxt  = S_WAIT_D1;
        end else begin
          w_rs_vld_nxt = 1'b0;
          case (rx_byte)
            8'hF1, 8'hF2, 8'hF3: w_state_nxt = S_WAIT_D1;
            8'hF0:               w_state_nxt = S_SYSEX;
            8'hF6: begin
              w_push     = 1'b1;
              w_push_dat = {8'hF6, 7'd0, 7'd0, 2'd1};
            end
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end else begin
        case (r_state)
          S_IDLE, S_WAIT_D1: begin
            if (r_state == S_WAIT_D1 || r_rs_vld) begin
              w_cur_nxt = w_d1_status;
              if (is_two_byte(w_d1_status)) begin
                w_push      = 1'b1;
                w_push_dat  = {w_d1_status, rx_byte[6:0], 7'd0, 2'd2};
                w_state_nxt = S_IDLE;
              end else begin
                w_d1_nxt    = rx_byte[6:0];
                w_state_nxt = S_WAIT_D2;
              end
            end else begin
              w_sync_err = 1'b1;
            end
          end
          S_WAIT_D2: begin
            w_push      = 1'b1;
            w_push_dat  = {w_d2_status, r_d1, rx_byte[6:0], 2'd3};
            w_state_nxt = S_IDLE;
          end
          default: w_state_nxt = r_state;
        endcase
      end
    end
  end

  // System and real-time messages (status Fx) bypass the channel filter.
  assign w_push_ok = w_push && ((w_push_dat[23:20] == 4'hF) || CHANNEL_MASK[w_push_dat[19:16]]);

  logic [23:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow, r_sync_err;
  logic          w_full, w_pop, w_wr;
  logic [23:0]   w_head;

  assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = msg_valid && msg_ready;
  assign w_wr   = w_push_ok && (!w_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rs_vld   <= 1'b0;
      r_rs       <= '0;
      r_cur      <= '0;
      r_d1       <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rs_vld   <= w_rs_vld_nxt;
      r_rs       <= w_rs_nxt;
      r_cur      <= w_cur_nxt;
      r_d1       <= w_d1_nxt;
      r_overflow <= w_push_ok && w_full && !w_pop;
      r_sync_err <= w_sync_err;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_push_dat;
  end

  assign w_head     = msg_valid ? r_mem[r_rd_ptr] : 24'd0;
  assign msg_valid  = (r_count != '0);
  assign msg_status = w_head[23:16];
  assign msg_data1  = w_head[15:9];
  assign msg_data2  = w_head[8:2];
  assign msg_len    = w_head[1:0];
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Scoreboard bench for midi_msg_parser: directed byte streams, expected messages queued at issue time.
module tb_midi_msg_parser;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       msg_valid, msg_ready;
  logic [7:0] msg_status;
  logic [6:0] msg_data1, msg_data2;
  logic [1:0] msg_len;
  logic [2:0] fifo_count;
  logic       overflow, sync_err;

  int total = 0;
  int bad   = 0;
  int n_sync = 0;
  int n_ovf  = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  midi_msg_parser #(
    .FIFO_DEPTH(4), .CHANNEL_MASK(16'hFFFD), .VEL0_TO_NOTE_OFF(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_status(msg_status),
    .msg_data1(msg_data1), .msg_data2(msg_data2), .msg_len(msg_len),
    .fifo_count(fifo_count), .overflow(overflow), .sync_err(sync_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_msg(input logic [7:0] s, input logic [6:0] d1, input logic [6:0] d2,
                            input logic [1:0] len);
    exp_q.push_back({s, d1, d2, len});
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte was sampled.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send(b0); send(b1); send(b2);
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 60 && (exp_q.size() != 0 || msg_valid); i++) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_count0"}, 32'(fifo_count), 32'd0);
  endtask

  always @(negedge clk) begin
    logic [23:0] got, e;
    if (!reset) begin
      if (sync_err) n_sync++;
      if (overflow) n_ovf++;
      if (msg_valid && msg_ready) begin
        got = {msg_status, msg_data1, msg_data2, msg_len};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_msg: got=%h expected=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL msg: got=%h expected=%h", got, e);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; msg_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",    32'(msg_valid),  32'd0);
    chk("rst_status",   32'(msg_status), 32'd0);
    chk("rst_data",     32'({msg_data1, msg_data2}), 32'd0);
    chk("rst_len",      32'(msg_len),    32'd0);
    chk("rst_count",    32'(fifo_count), 32'd0);
    chk("rst_flags",    32'({overflow, sync_err}), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Note On then running status with velocity 0 -> Note Off
    expect_msg(8'h90, 7'h3C, 7'h64, 2'd3);
    send_seq(8'h90, 8'h3C, 8'h64);
    chk("latency_valid", 32'(msg_valid), 32'd1);
    chk("latency_count", 32'(fifo_count), 32'd1);
    expect_msg(8'h80, 7'h3E, 7'h00, 2'd3);
    send(8'h3E); send(8'h00);

    // Two-byte messages, system common, orphan data
    expect_msg(8'hC5, 7'h07, 7'h00, 2'd2);
    expect_msg(8'hC5, 7'h08, 7'h00, 2'd2);
    send_seq(8'hC5, 8'h07, 8'h08);
    expect_msg(8'hF2, 7'h01, 7'h02, 2'd3);
    send_seq(8'hF2, 8'h01, 8'h02);
    send(8'h40);
    chk("sync_err_orphan", 32'(sync_err), 32'd1);
    drain("t2");

    // Real-time byte mid-message
`ifdef MIDI_DEC_REALTIME_EN
    expect_msg(8'hF8, 7'h00, 7'h00, 2'd1);
`endif
    expect_msg(8'h90, 7'h3C, 7'h64, 2'd3);
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    drain("t3");

    // Channel 1 filtered out, channel 0 accepted
    send_seq(8'h91, 8'h3C, 8'h64);
    expect_msg(8'h90, 7'h3C, 7'h64, 2'd3);
    send_seq(8'h90, 8'h3C, 8'h64);
    // Aborted partial message, new status takes over
    send(8'h90); send(8'h3C); send(8'hC5);
    chk("sync_err_abort", 32'(sync_err), 32'd1);
    expect_msg(8'hC5, 7'h09, 7'h00, 2'd2);
    send(8'h09);
    drain("t4");

    // FIFO full: fifth message dropped
    msg_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) expect_msg(8'h90, 7'(8'h10 + k), 7'h40, 2'd3);
      send_seq(8'h90, 8'(8'h10 + k), 8'h40);
    end
    chk("ovf_pulse",  32'(overflow),   32'd1);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("head_hold",  32'({msg_status, msg_data1}), 32'({8'h90, 7'h10}));
    @(posedge clk); #1;
    chk("ovf_one_cycle", 32'(overflow), 32'd0);
    msg_ready = 1'b1;
    drain("t5a");

    // FIFO full with simultaneous pop: no drop
    msg_ready = 1'b0;
    for (int k = 0; k < 5; k++) expect_msg(8'h90, 7'(8'h20 + k), 7'h40, 2'd3);
    for (int k = 0; k < 4; k++) send_seq(8'h90, 8'(8'h20 + k), 8'h40);
    send(8'h90); send(8'h24);
    msg_ready = 1'b1;
    send(8'h40);
    chk("no_ovf", 32'(overflow), 32'd0);
    chk("full_swap_count", 32'(fifo_count), 32'd4);
    drain("t5b");

    // SysEx discarded
    expect_msg(8'h93, 7'h40, 7'h7F, 2'd3);
    send_seq(8'hF0, 8'h11, 8'h22);
    send_seq(8'h93, 8'h40, 8'h7F);
    drain("t6");

    // Reset mid-message loses partial and running status
    send(8'h90);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    send(8'h3C); send(8'h64);
    chk("sync_err_after_reset", 32'(sync_err), 32'd1);
    chk("no_msg_after_reset", 32'(msg_valid), 32'd0);
    drain("t7");

    repeat (3) @(posedge clk);
    #1;
    chk("sync_err_total", 32'(n_sync), 32'd4);
    chk("overflow_total", 32'(n_ovf),  32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midi_msg_parser.md
# midi_msg_parser

Parametrised MIDI message parser. It sits between the MIDI UART receiver and the voice allocator. It turns the received byte stream into complete, length-tagged MIDI messages with running status, variable message length, per-channel filtering and real-time byte interleaving. Parsed messages are buffered in a small first-word-fall-through FIFO with a valid/ready handshake.

## Interface
Parameters:
- FIFO_DEPTH, 4, message FIFO entries; power of two, ≥2.
- CHANNEL_MASK, 16'hFFFF, bit n set = accept channel-voice messages on channel n.
- VEL0_TO_NOTE_OFF, 1, when 1, Note On (9n) with velocity 0 is emitted as status 8n, same key, data2 = 0.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- rx_valid  in  1  one-cycle strobe, rx_byte holds a received byte.
- rx_byte  in  8  received byte.
- msg_valid  out  1  FIFO head holds a message.
- msg_ready  in  1  consumer accepts head when msg_valid && msg_ready.
- msg_status  out  8  status byte of head message.
- msg_data1  out  7  first data byte (0 if unused).
- msg_data2  out  7  second data byte (0 if unused).
- msg_len  out  2  total bytes in message, including status: 1, 2 or 3.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held.
- overflow  out  1  one-cycle pulse when a complete message is dropped because the FIFO is full.
- sync_err  out  1  one-cycle pulse on an orphan data byte or an aborted partial message.

## Operation
- Byte classes:
  - Data: 00–7F.
  - Channel voice: 80–EF. Lengths: 8n, 9n, An, Bn, En = 3; Cn, Dn = 2.
  - System common: F0–F7.
  - Real-time: F8–FF.
- Parser states: IDLE, WAIT_D1, WAIT_D2, SYSEX. A running-status register rs holds 8 bits plus a valid bit.
- IDLE:
  - Channel-voice status: load rs and go to WAIT_D1.
  - Data byte with rs valid: treat it as data1 under rs (running status).
  - Data byte with rs invalid: discard it and pulse sync_err.
- WAIT_D1, on a data byte:
  - 2-byte message: emit it, return to IDLE.
  - Otherwise: store data1 and go to WAIT_D2.
- WAIT_D2, on a data byte: emit the 3-byte message and return to IDLE. rs is kept.
- Non-real-time status byte arriving in WAIT_D1 or WAIT_D2: drop the partial message, pulse sync_err, then process the new byte as if received in IDLE.
- System common bytes always clear rs:
  - F1, F3: 2-byte messages.
  - F2: 3-byte message.
  - F6: emitted immediately with len 1.
  - F0: enter SYSEX; all data bytes there are discarded. F7 or any non-real-time status exits SYSEX (the status byte is then processed normally).
  - F4, F5, lone F7: ignored.
- Real-time bytes never change state, rs or the partial message. Handling is set by the configuration macro.
- Channel filter: channel-voice messages on a channel whose CHANNEL_MASK bit is 0 are fully parsed but not pushed. System messages are never filtered.
- FIFO:
  - Push happens on message completion.
  - Pop happens when msg_valid && msg_ready.
  - Push while full with no pop: message dropped and overflow pulsed.
  - Push and pop together while full: both take effect, no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset clears FIFO, state, rs and all outputs. Partial messages are lost.

## Timing
- Every rx_valid strobe is consumed in its cycle; there is no input backpressure. rx_valid may be asserted on consecutive cycles.
- Latency: a final byte sampled at edge k makes msg_valid high after edge k (FIFO was empty), with head fields valid in the same cycle.
- Head fields hold stable while msg_valid && !msg_ready.
- fifo_count updates on the same edge as a push or pop.
- overflow and sync_err are registered and high exactly one cycle after the offending byte edge.
- Reset values: msg_valid 0, msg_status 00, msg_data1 0, msg_data2 0, msg_len 0, fifo_count 0, overflow 0, sync_err 0.

## Configuration
- MIDI_DEC_REALTIME_EN defined: each real-time byte except FD (undefined) is pushed immediately as a len-1 message. This holds even mid-message; it is not filtered.
- MIDI_DEC_REALTIME_EN undefined: real-time bytes are silently discarded. The parser state is unaffected either way.

## Test plan
- Bytes 90 3C 64, then 3E 00 (running status), with VEL0_TO_NOTE_OFF=1 -> {90,3C,64,len3}, then {80,3E,00,len3}.
- Bytes C5 07, then 08 -> {C5,07,00,len2}, then {C5,08,00,len2}. Next, F2 01 02 -> {F2,01,02,len3}; then a lone 40 -> sync_err pulse, no message (rs cleared).
- Bytes 90 3C F8 64 with macro defined -> {F8,len1} first, then {90,3C,64,len3}. Same sequence with macro undefined -> only the Note On.
- CHANNEL_MASK=16'h0001: bytes 91 3C 64 -> no message. Bytes 90 3C 64 -> message pushed.
- FIFO_DEPTH=4, msg_ready=0, five complete Note Ons -> fifo_count=4, one overflow pulse on the fifth. Five Note Ons sent while msg_ready=1 on the completion cycle of the fifth -> no overflow.
- Bytes F0 11 22, then 93 40 7F -> sysex discarded, then {93,40,7F,len3}. Reset asserted between 90 and 3C -> following 64 gives sync_err, no message.
